// File: rtl/column_drop_allocator.sv
// Connect-4 drop engine: keeps a fill counter per column, turns a column strobe into a
// cell index, offers it over valid/ready and tracks turn, column and board fill state.
module column_drop_allocator #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int POS_W = 5,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [COLS-1:0]  selected_column,
    input  logic             sel_valid,
    input  logic             pos_ready,
    output logic             pos_valid,
    output logic [POS_W-1:0] column_position,
    output logic [COL_W-1:0] c_register,
    output logic             player,
    output logic [COLS-1:0]  col_full,
    output logic             board_full,
    output logic             reject,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OFFER = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [ROW_W-1:0] count [COLS];

    logic [COLS-1:0]  sel_n;
    logic [COL_W-1:0] sel_col;
    logic             sel_one;
    logic             legal;
    logic             handshake;
    logic [ROW_W-1:0] count_inc;
    logic [COLS-1:0]  full_after;

    // Handshake: a position transfers on any rising edge where pos_valid and pos_ready
    // are both high; once raised, pos_valid and its payload hold until that edge.
    always_comb begin
        sel_n   = ~selected_column;
        sel_col = '0;
        for (int i = 0; i < COLS; i++) begin
            if (sel_n[i]) sel_col = COL_W'(i);
        end
        sel_one    = ($countones(sel_n) == 1);
        legal      = sel_one && !enable && !col_full[sel_col];
        handshake  = (state == OFFER) && pos_valid && pos_ready;
        count_inc  = count[c_register] + ROW_W'(1);
        full_after = col_full;
        full_after[c_register] = (count_inc == ROW_W'(ROWS));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            for (int i = 0; i < COLS; i++) count[i] <= '0;
            pos_valid       <= 1'b0;
            column_position <= '1;
            c_register      <= '0;
            player          <= 1'b0;
            col_full        <= '0;
            board_full      <= 1'b0;
            reject          <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (clear) begin
                // A clear wins over any handshake or selection in the same cycle.
                state           <= IDLE;
                for (int i = 0; i < COLS; i++) count[i] <= '0;
                pos_valid       <= 1'b0;
                column_position <= '1;
                player          <= 1'b0;
                col_full        <= '0;
                board_full      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_valid) begin
                            if (legal) begin
                                state           <= OFFER;
                                pos_valid       <= 1'b1;
                                column_position <= POS_W'(count[sel_col]) * POS_W'(COLS)
                                                   + POS_W'(sel_col);
                                c_register      <= sel_col;
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    OFFER: begin
                        if (sel_valid) reject <= 1'b1;
                        if (handshake) begin
                            count[c_register] <= count_inc;
                            player            <= ~player;
                            pos_valid         <= 1'b0;
                            column_position   <= '1;
                            col_full          <= full_after;
                            board_full        <= &full_after;
                            state             <= (&full_after) ? DONE : IDLE;
                        end
                    end
                    DONE: begin
                        if (sel_valid) reject <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/column_drop_allocator.md
Name: column_drop_allocator

Overview:
- Parametrised drop-position engine for the Connect-4 board. Owns one fill counter per column, turns a player column selection into a linear cell index, and offers it to the board register writer over a valid/ready handshake.
- Also tracks whose turn it is, per-column and board-full status, and rejects illegal moves.
- Sits between the debounced column-button logic and the board storage / VGA cell registers.

Parameters:
- COLS, 4, number of board columns (≥2).
- ROWS, 4, number of board rows (≥1).
- POS_W, 5, width of column_position. COLS*ROWS must be < 2^POS_W; the all-ones value means "no cell".
- COL_W, $clog2(COLS), width of the column index.
- ROW_W, $clog2(ROWS+1), width of each fill counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  active-high hold; while 1, new selections are rejected.
- clear  input  1  synchronous new-game clear.
- selected_column  input  COLS  active-low one-hot column select; bit i low selects column i.
- sel_valid  input  1  one-cycle strobe qualifying selected_column.
- pos_ready  input  1  board writer accepts the offered position.
- pos_valid  output  1  offered position is valid.
- column_position  output  POS_W  cell index = row*COLS + col; all-ones when idle.
- c_register  output  COL_W  column index of the offered move.
- player  output  1  player to move (0 or 1).
- col_full  output  COLS  bit i set when counter[i] == ROWS.
- board_full  output  1  all columns full.
- reject  output  1  one-cycle pulse for an illegal or ignored selection.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (rst_n=0, async): all counters 0; state IDLE; pos_valid=0; column_position=all-ones; c_register=0; player=0; reject=0; col_full=0; board_full=0.
- The FSM has three states: IDLE, OFFER, DONE.
- IDLE, accepted move: on sel_valid=1 with enable=0, exactly one low bit in selected_column, and that column not full, on the next edge:
  - state goes to OFFER, pos_valid goes to 1;
  - column_position = counter[col]*COLS + col, computed at POS_W width;
  - c_register = col.
  - Latency from sel_valid to pos_valid is 1 cycle.
- IDLE, rejected move: sel_valid=1 with enable=1, zero or multiple low bits, or the selected column full gives reject=1 for exactly one cycle on the next edge. State and counters are unchanged.
- OFFER:
  - column_position, c_register and pos_valid stay stable until pos_valid & pos_ready.
  - On the handshake edge: counter[col] increments, player toggles, pos_valid=0, column_position=all-ones.
  - Next state is DONE if that move filled the board, otherwise IDLE.
  - Any sel_valid seen in OFFER is dropped with a reject pulse.
- DONE: board_full=1; every sel_valid is rejected; the block leaves DONE only via clear or reset.
- col_full and board_full are registered. They update on the same edge as the counter increment.
- clear=1 (any state): on the next edge, counters=0, player=0, state=IDLE, pos_valid=0, column_position=all-ones, reject=0.
  - clear has priority over a simultaneous handshake; that move is discarded and the counter is not incremented.
  - clear also has priority over a simultaneous sel_valid, which is ignored without a reject pulse.
- The counter never exceeds ROWS; there is no wrap-around.
- busy = (state != IDLE).
- reject and pos_valid are never high in the same cycle for the same selection.

Test Plan:
All scenarios use COLS=4, ROWS=4.
- Single move: after reset, sel_valid with selected_column=4'b1101 and pos_ready=1 → next cycle pos_valid=1, column_position=1, c_register=1. After the handshake, player=1 and pos_valid=0.
- Column fill: five moves on 4'b1110 → positions 0, 4, 8, 12. col_full[0]=1 after the 4th handshake. The 5th selection gives a single reject pulse and pos_valid stays 0.
- Backpressure: offer column 3 with pos_ready=0 for 3 cycles → column_position=3 and c_register=3 held stable. A sel_valid on 4'b1110 during the wait is rejected. pos_ready=1 → counter[3]=1.
- Illegal selects: selected_column=4'b1100, then 4'b1111, then 4'b1110 with enable=1 → three reject pulses, no pos_valid, counters unchanged.
- Board full: 16 accepted moves → board_full=1, state DONE, busy=1. A 17th sel_valid is rejected. clear=1 → all counters 0, player=0, board_full=0.
- Clear/reset mid-offer: clear asserted in the same cycle as pos_ready while in OFFER → counter not incremented, pos_valid=0. rst_n pulsed low mid-OFFER → all outputs return to their reset values immediately (asynchronously).
